// File: rtl/dmem_lsu.sv
// Load/store unit in front of a combinational-read, synchronous-write word RAM.
// Handles byte/halfword/word accesses, sub-word read-modify-write and error flagging.
//
// state  | meaning
// IDLE   | ready for a request; illegal requests go straight to RESP
// ACCESS | RAM addressed; load lane extracted or store word written
// RESP   | response held until rsp_ready_i
module dmem_lsu #(
    parameter int DEPTH = 128,
    parameter int ABITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             ram_we_o,
    output logic [ABITS-1:0] ram_adr_o,
    output logic [31:0]      ram_din_o,
    input  logic [31:0]      ram_dout_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e           state_q;
    logic             we_q;
    logic             signed_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic [31:0]      wdata_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_q;
    logic             ram_we_q;
    logic [ABITS-1:0] ram_adr_q;

    logic             illegal;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic [31:0]      merged;

    always_comb begin
        illegal = 1'b0;
        case (req_size_i)
            2'b01:   illegal = req_addr_i[0];
            2'b10:   illegal = |req_addr_i[1:0];
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
        if ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH)) illegal = 1'b1;
    end

    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = ram_dout_i[7:0];
            2'd1:    byte_sel = ram_dout_i[15:8];
            2'd2:    byte_sel = ram_dout_i[23:16];
            default: byte_sel = ram_dout_i[31:24];
        endcase
        half_sel = lane_q[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_val = ram_dout_i;
        endcase
    end

    // Sub-word stores splice the new lane into the word currently in RAM.
    always_comb begin
        merged = ram_dout_i;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_adr_q   <= '0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (illegal) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q   <= ACCESS;
                            we_q      <= req_we_i;
                            size_q    <= req_size_i;
                            signed_q  <= req_signed_i;
                            lane_q    <= req_addr_i[1:0];
                            wdata_q   <= req_wdata_i;
                            ram_adr_q <= ABITS'(req_addr_i[31:2]);
                            ram_we_q  <= req_we_i;
                        end
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= we_q ? 32'h0 : load_val;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign ram_we_o    = ram_we_q;
    assign ram_adr_o   = ram_adr_q;
    assign ram_din_o   = ram_we_q ? merged : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: models the attached RAM and checks responses against a
// byte-lane reference memory, with directed cases followed by random traffic.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [31:0] ram_adr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [128] = '{default: 32'h0};
    logic [31:0] ref_mem [128] = '{default: 32'h0};
    int          we_cnt = 0;
    logic [31:0] last_adr = '0;
    logic [31:0] last_din = '0;

    int errors = 0;
    int checks = 0;

    dmem_lsu #(.DEPTH(128), .ABITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_din_o(ram_din),
        .ram_dout_i(ram_dout)
    );

    always #5 clk = ~clk;

    assign ram_dout = (ram_adr < 32'd128) ? mem[ram_adr[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_adr < 32'd128) mem[ram_adr[6:0]] <= ram_din;
            we_cnt   <= we_cnt + 1;
            last_adr <= ram_adr;
            last_din <= ram_din;
        end
    end

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Reference: plain byte-lane arithmetic on a word array.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err, output logic [31:0] exp_word);
        int unsigned idx, sh;
        logic [31:0] w, mask, v;
        idx = ad / 4;
        sh  = (ad % 4) * 8;
        exp_err = (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) ||
                  (sz == 2'd2 && ad % 4 != 0) || (idx >= 128);
        exp_rd = 32'h0;
        exp_word = 32'h0;
        if (exp_err) return;
        w = ref_mem[idx];
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (we) begin
            exp_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx] = exp_word;
        end else begin
            v = (w >> sh) & mask;
            if (sg && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
            if (sg && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            exp_rd = v;
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input int hold,
                       input bit early, output logic [31:0] got);
        logic [31:0] er, ed, held;
        logic        ee;
        int          lat, w0;
        model(we, sz, sg, ad, wd, er, ee, ed);
        @(negedge clk);
        check(tag, "req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; rsp_ready = early;
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check(tag, "latency", 32'(lat), ee ? 32'd1 : 32'd2);
        check(tag, "rdata", rsp_rdata, er);
        check(tag, "err", 32'(rsp_err), 32'(ee));
        got = rsp_rdata;
        held = rsp_rdata;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check(tag, "hold_valid", 32'(rsp_valid), 32'd1);
                check(tag, "hold_rdata", rsp_rdata, held);
                check(tag, "hold_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check(tag, "valid_drop", 32'(rsp_valid), 32'd0);
        check(tag, "ready_back", 32'(req_ready), 32'd1);
        check(tag, "we_pulses", 32'(we_cnt - w0), (we && !ee) ? 32'd1 : 32'd0);
        if (we && !ee) begin
            check(tag, "ram_adr", last_adr, ad >> 2);
            check(tag, "ram_din", last_din, ed);
            check(tag, "mem", mem[ad[8:2]], ref_mem[ad[8:2]]);
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] keep;
        #1;
        check("reset", "req_ready", 32'(req_ready), 32'd1);
        check("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset", "rsp_rdata", rsp_rdata, 32'd0);
        check("reset", "rsp_err", 32'(rsp_err), 32'd0);
        check("reset", "ram_we", 32'(ram_we), 32'd0);
        check("reset", "ram_adr", ram_adr, 32'd0);
        check("reset", "ram_din", ram_din, 32'd0);
        #12 rst_n = 1'b1;

        txn("st_word", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, got);
        check("st_word", "din_const", last_din, 32'hDEADBEEF);
        txn("ld_word", 0, 2'd2, 0, 32'h10, 32'h0, 0, 0, got);
        check("ld_word", "const", got, 32'hDEADBEEF);

        txn("st_pre", 1, 2'd2, 0, 32'h10, 32'h11223344, 0, 0, got);
        txn("st_byte", 1, 2'd0, 0, 32'h12, 32'h000000AA, 0, 0, got);
        check("st_byte", "din_const", last_din, 32'h11AA3344);
        txn("ld_sbyte", 0, 2'd0, 1, 32'h12, 32'h0, 0, 0, got);
        check("ld_sbyte", "const", got, 32'hFFFFFFAA);
        txn("ld_ubyte", 0, 2'd0, 0, 32'h12, 32'h0, 0, 0, got);
        check("ld_ubyte", "const", got, 32'h000000AA);

        txn("st_half_pre", 1, 2'd2, 0, 32'h10, 32'h80017FFF, 0, 0, got);
        txn("ld_shalf", 0, 2'd1, 1, 32'h12, 32'h0, 0, 0, got);
        check("ld_shalf", "const", got, 32'hFFFF8001);
        txn("ld_half_lo", 0, 2'd1, 1, 32'h10, 32'h0, 0, 0, got);
        check("ld_half_lo", "const", got, 32'h00007FFF);

        txn("err_half13", 1, 2'd1, 0, 32'h13, 32'h1234, 0, 0, got);
        txn("err_word06", 1, 2'd2, 0, 32'h06, 32'h1234, 0, 0, got);
        txn("err_size3", 0, 2'd3, 0, 32'h10, 32'h0, 0, 0, got);
        txn("err_range", 1, 2'd2, 0, 32'h200, 32'h5555, 0, 0, got);

        txn("backpressure", 0, 2'd2, 0, 32'h10, 32'h0, 5, 0, got);
        txn("early_ready", 0, 2'd0, 0, 32'h11, 32'h0, 0, 1, got);

        // Reset during the ACCESS cycle of a store must cancel the write.
        keep = mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid", "ram_we_access", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid", "ram_we", 32'(ram_we), 32'd0);
        check("rst_mid", "req_ready", 32'(req_ready), 32'd1);
        check("rst_mid", "rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid", "rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mid", "rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mid", "ram_adr", ram_adr, 32'd0);
        check("rst_mid", "ram_din", ram_din, 32'd0);
        @(negedge clk);
        check("rst_mid", "word4", mem[4], keep);
        rst_n = 1'b1;
        txn("rst_reload", 0, 2'd2, 0, 32'h10, 32'h0, 0, 0, got);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ad;
            logic [1:0]  sz;
            int          hold;
            bit          early;
            ad = ($urandom_range(0, 135) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 31) == 0) ad = $urandom;
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            early = ($urandom_range(0, 3) == 0);
            hold = early ? 0 : $urandom_range(0, 3);
            txn("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                ad, $urandom, hold, early, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit placed directly upstream of the data memory, the 128-word, 32-bit RAM with combinational read and synchronous write. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake. It converts byte addresses to word indices and performs read-modify-write for sub-word stores. Loads return sign- or zero-extended data, and misaligned or out-of-range accesses are flagged.

## Interface
- DEPTH, 128, number of 32-bit words in the attached RAM.
- ABITS, 32, width of the RAM word-address port.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and flagged as an error.
- req_signed  in  1  sign-extend sub-word loads; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.
- ram_we  out  1  RAM write enable.
- ram_adr  out  ABITS  RAM word index, equal to the latched req_addr[31:2].
- ram_din  out  32  RAM write data (merged word).
- ram_dout  in  32  RAM combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS: on req_valid && req_ready, for a legal request. Latch we, size, signed, addr and wdata.
- IDLE → RESP: on handshake of an illegal request. Set rsp_err=1 and rsp_rdata=0. RAM is not touched.
- Illegal means any of:
  - size==11;
  - size==01 with addr[0]≠0;
  - size==10 with addr[1:0]≠00;
  - addr[31:2] ≥ DEPTH.
- ACCESS, always: ram_adr = latched addr[31:2]. Next state is RESP.
- ACCESS, load:
  - Select the lane from ram_dout, little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
  - Extend per req_signed and register the result into rsp_rdata.
- ACCESS, store: ram_we=1 for exactly this cycle.
  - Word store: ram_din = wdata.
  - Byte/halfword store: ram_din = ram_dout with the addressed lane replaced by wdata[7:0] or wdata[15:0]. All other bytes are preserved.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are stable. On rsp_ready, go to IDLE.
- ram_we is 0 in every state except a store in ACCESS.
- ram_adr holds its last value outside ACCESS.
- A store in ACCESS never sets rsp_err.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, req_ready=1;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - ram_we=0, ram_adr=0, ram_din=0.
- Request accepted at edge N:
  - ACCESS during cycle N+1; any RAM write commits at edge N+2.
  - rsp_valid is asserted from cycle N+2.
- Error request accepted at edge N: rsp_valid from cycle N+1.
- Throughput: at most one request per 3 cycles.
- req_ready=0 from ACCESS until the cycle after the response handshake.
- rsp_ready may be held high in advance: response is accepted in the first RESP cycle and IDLE follows next cycle.
- Reset asserted during ACCESS: ram_we drops immediately and the write does not commit. Reset during RESP: the response is discarded.
- Load data reflects RAM contents as of the ACCESS cycle, including any store committed at the preceding edge.

## Test plan
- Word store then load: store addr 0x10, data 0xDEADBEEF.
  - ram_we pulses one cycle with ram_adr=4, ram_din=0xDEADBEEF.
  - Load of 0x10 returns 0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Byte RMW: word 4 = 0x11223344; byte store of 0xAA at 0x12.
  - ram_din = 0x11AA3344.
  - Signed byte load at 0x12 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
- Halfword load: word 4 = 0x8001_7FFF.
  - Signed load at 0x12 returns 0xFFFF8001.
  - Load at 0x10 returns 0x00007FFF.
- Errors, each: rsp_err=1, rsp_rdata=0, ram_we never asserted, rsp_valid 1 cycle after accept.
  - halfword at 0x13;
  - word at 0x06;
  - size 11;
  - word at 0x200 (index 128 ≥ DEPTH).
- Backpressure: hold rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_rdata stay stable; req_ready stays 0.
  - A second req_valid is not accepted until one cycle after the handshake.
- Reset mid-store: pull rst_n low during ACCESS of a store to word 4.
  - ram_we falls immediately; word 4 is unchanged.
  - All outputs take their reset values and req_ready=1.
